// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of TotalALU.
// Accepts one op (opcode + two operands) on a valid/ready request port, drives
// TotalALU's dataA/dataB/Signal, waits the fixed latency of the selected unit,
// captures TotalALU's Output and returns it on a valid/ready response port.
// Ops are fully serialised, so MFHI/MFLO can never overtake a MULTU.
// Ports:
//   clk, reset            clock and async active-high reset (shared with TotalALU)
//   in_valid/in_ready     request handshake; in_op/in_a/in_b request payload
//   alu_dataA/B, alu_signal  operands and function code to TotalALU (0 = NOP)
//   alu_output            TotalALU result
//   out_valid/out_ready   response handshake; out_data result, out_err illegal op
//   busy                  high whenever not IDLE
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned MUL_LAT = 33,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_output,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        busy
);

  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLL   = 6'b000010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_NOP   = 6'b000000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               in_ready_n, out_valid_n, out_err_n, busy_n;
  logic [31:0]        out_data_n, dataA_n, dataB_n;
  logic [5:0]         signal_n;

  // Opcodes TotalALU implements; anything else is answered with out_err.
  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_SLL, OP_MULTU, OP_MFHI, OP_MFLO: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
      out_data   <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_signal <= OP_NOP;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_err    <= out_err_n;
      out_data   <= out_data_n;
      alu_dataA  <= dataA_n;
      alu_dataB  <= dataB_n;
      alu_signal <= signal_n;
      busy       <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    out_err_n  = out_err;
    out_data_n = out_data;
    dataA_n    = alu_dataA;
    dataB_n    = alu_dataB;
    signal_n   = alu_signal;

    case (state)
      IDLE: begin
        if (in_valid) begin
          dataA_n = in_a;
          dataB_n = in_b;
          if (is_legal(in_op)) begin
            signal_n  = in_op;
            out_err_n = 1'b0;
            cnt_n     = (in_op == OP_MULTU) ? CNT_W'(MUL_LAT - 1) : CNT_W'(ALU_LAT - 1);
            state_n   = EXEC;
          end else begin
            out_err_n  = 1'b1;
            out_data_n = '0;
            state_n    = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          // MULTU only writes HiLo; its response carries no data.
          out_data_n = (alu_signal == OP_MULTU) ? 32'd0 : alu_output;
          signal_n   = OP_NOP;
          state_n    = RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          out_err_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Handshake flags are registered copies of the next state.
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == RESP);
    busy_n      = (state_n != IDLE);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural TotalALU stub drives alu_output,
// a stimulus process issues directed and random ops and queues expected
// responses, and a monitor pops and compares on every response handshake.
module tb_alu_op_sequencer;

  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned MUL_LAT = 33;

  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLL   = 6'b000010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] alu_dataA, alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_output;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;

  alu_op_sequencer #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_output(alu_output),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 9) < 7);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // TotalALU stub: registered output one cycle after the operands; MULTU
  // writes HiLo after holding the multiply for a while.
  logic [31:0] stub_out, hi, lo;
  int          mul_cnt;
  assign alu_output = stub_out;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_out <= '0; hi <= '0; lo <= '0; mul_cnt <= 0;
    end else begin
      mul_cnt <= (alu_signal == OP_MULTU) ? mul_cnt + 1 : 0;
      case (alu_signal)
        OP_AND:  stub_out <= alu_dataA & alu_dataB;
        OP_OR:   stub_out <= alu_dataA | alu_dataB;
        OP_ADD:  stub_out <= alu_dataA + alu_dataB;
        OP_SUB:  stub_out <= alu_dataA - alu_dataB;
        OP_SLT:  stub_out <= ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
        OP_SLL:  stub_out <= alu_dataA << alu_dataB[4:0];
        OP_MFHI: stub_out <= hi;
        OP_MFLO: stub_out <= lo;
        OP_MULTU: begin
          stub_out <= '0;
          if (mul_cnt == int'(MUL_LAT) - 2) {hi, lo} <= 64'(alu_dataA) * 64'(alu_dataB);
        end
        default: stub_out <= '0;
      endcase
    end
  end

  // Reference model state and scoreboard.
  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic logic legal(input logic [5:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_MULTU, OP_MFHI, OP_MFLO};
  endfunction

  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request; returns the cycle number of the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
    int   t;
    exp_t x;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    x.d = model(op, a, b);
    x.e = !legal(op);
    exp_q.push_back(x);
    if (op == OP_MULTU) {m_hi, m_lo} = 64'(a) * 64'(b);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    in_op = 6'($urandom); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: scoreboard compare on handshake, stability while stalled,
  // and invariants that hold every cycle.
  logic        stalled = 1'b0;
  logic [31:0] prev_data;
  logic        prev_err;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      check("signal_legal_or_nop", 32'(alu_signal == 6'd0 || legal(alu_signal)), 32'd1);
      if (out_valid) begin
        check("resp_in_ready_low", 32'(in_ready), 32'd0);
        check("resp_signal_nop", 32'(alu_signal), 32'd0);
        if (stalled) begin
          check("stall_data_stable", out_data, prev_data);
          check("stall_err_stable", 32'(out_err), 32'(prev_err));
        end
        if (out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_response", 32'd1, 32'd0);
          end else begin
            exp_t x;
            x = exp_q.pop_front();
            check("out_data", out_data, x.d);
            check("out_err", 32'(out_err), 32'(x.e));
          end
        end else begin
          stalled = 1'b1;
          prev_data = out_data;
          prev_err = out_err;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, acc2, n;
    logic [5:0]  op;
    logic [5:0]  ops[9];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_MULTU, OP_MFHI, OP_MFLO};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_signal", 32'(alu_signal), 32'd0);
    check("rst_dataA", alu_dataA, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // ADD 5+3 and response latency.
    rdy_mode = 1;
    issue(OP_ADD, 32'd5, 32'd3, acc);
    check("add_busy", 32'(busy), 32'd1);
    wait_valid(n);
    check("add_latency", 32'(n), 32'(ALU_LAT + 1));
    drain();

    // SUB and SLT.
    issue(OP_SUB, 32'd3, 32'd5, acc);
    issue(OP_SLT, 32'd3, 32'd5, acc);
    drain();

    // MULTU then MFHI/MFLO; MFHI is held off until MULTU completes.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, acc);
    issue(OP_MFHI, 32'd0, 32'd0, acc2);
    check("mfhi_held_off", 32'(acc2 - acc >= int'(MUL_LAT) + 2), 32'd1);
    issue(OP_MFLO, 32'd0, 32'd0, acc);
    drain();

    // Illegal opcode.
    issue(6'b111111, 32'd7, 32'd9, acc);
    wait_valid(n);
    check("illegal_latency", 32'(n), 32'd1);
    check("illegal_err", 32'(out_err), 32'd1);
    drain();

    // SLL with response back-pressure.
    rdy_mode = 2;
    issue(OP_SLL, 32'd1, 32'd4, acc);
    repeat (12) @(negedge clk);
    check("sll_stall_valid", 32'(out_valid), 32'd1);
    check("sll_stall_data", out_data, 32'd16);
    rdy_mode = 1;
    drain();

    // Reset in the middle of a MULTU.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd3, acc);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_signal", 32'(alu_signal), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, acc);
    drain();

    // Random ops with random back-pressure.
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      issue(op, $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
